spr_re_gamma_ctrl: RTL and testbench



---
 rtl/spr_gamma_pkg.sv | 16 +
 rtl/spr_de_gamma_lut.sv | 57 +++++
 rtl/spr_re_gamma_ctrl.sv | 158 +++++++++++++++
 tb/tb_spr_re_gamma_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spr_gamma_pkg.sv
// Shared constants and FSM encoding for the re-gamma segment search.
package spr_gamma_pkg;

    localparam int LIN_W   = 11;
    localparam int CODE_W  = 5;
    localparam int NUM_CH  = 3;
    localparam int SEG_NUM = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FETCH  = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/spr_de_gamma_lut.sv
// De-gamma breakpoint table: returns b[idx] and b[idx+1] for one segment index.
module spr_de_gamma_lut
    import spr_gamma_pkg::*;
(
    input  logic [CODE_W-1:0] idx_i,
    output logic [LIN_W-1:0]  lobound_o,
    output logic [LIN_W-1:0]  upbound_o
);

    // b[SEG_NUM] is the closing bound of the last segment.
    function automatic logic [LIN_W-1:0] bp(input logic [CODE_W:0] k);
        logic [LIN_W-1:0] v;
        case (k)
            6'd0:    v = 11'd0;
            6'd1:    v = 11'd32;
            6'd2:    v = 11'd64;
            6'd3:    v = 11'd96;
            6'd4:    v = 11'd128;
            6'd5:    v = 11'd160;
            6'd6:    v = 11'd192;
            6'd7:    v = 11'd224;
            6'd8:    v = 11'd256;
            6'd9:    v = 11'd288;
            6'd10:   v = 11'd320;
            6'd11:   v = 11'd352;
            6'd12:   v = 11'd384;
            6'd13:   v = 11'd424;
            6'd14:   v = 11'd462;
            6'd15:   v = 11'd502;
            6'd16:   v = 11'd576;
            6'd17:   v = 11'd648;
            6'd18:   v = 11'd728;
            6'd19:   v = 11'd808;
            6'd20:   v = 11'd880;
            6'd21:   v = 11'd952;
            6'd22:   v = 11'd1084;
            6'd23:   v = 11'd1200;
            6'd24:   v = 11'd1312;
            6'd25:   v = 11'd1424;
            6'd26:   v = 11'd1536;
            6'd27:   v = 11'd1648;
            6'd28:   v = 11'd1760;
            6'd29:   v = 11'd1856;
            6'd30:   v = 11'd1952;
            6'd31:   v = 11'd2038;
            default: v = 11'd2040;
        endcase
        return v;
    endfunction

    logic [CODE_W:0] idx_ext;

    assign idx_ext   = {1'b0, idx_i};
    assign lobound_o = bp(idx_ext);
    assign upbound_o = bp(idx_ext + 6'd1);

endmodule

// File: rtl/spr_re_gamma_ctrl.sv
// Inverse de-gamma sequencer: per-channel binary search over one shared LUT,
// returning segment code, clamped residue and span for the re-gamma interpolator.
//   state  | meaning
//   IDLE   | waiting for a pixel, in_ready high
//   SEARCH | one trial bit of the binary search per cycle
//   FETCH  | LUT at final k, commit code/res/span for current channel
//   DONE   | result presented until out_ready
module spr_re_gamma_ctrl #(
    parameter int NUM_CH = spr_gamma_pkg::NUM_CH,
    parameter int LIN_W  = spr_gamma_pkg::LIN_W,
    parameter int CODE_W = spr_gamma_pkg::CODE_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*LIN_W-1:0]  in_lin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*CODE_W-1:0] out_code,
    output logic [NUM_CH*LIN_W-1:0]  out_res,
    output logic [NUM_CH*LIN_W-1:0]  out_span
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BIT_W = $clog2(CODE_W);
    localparam logic [BIT_W-1:0]  BIT_TOP   = BIT_W'(CODE_W - 1);
    localparam logic [CODE_W-1:0] IDX_FIRST = CODE_W'(1) << (CODE_W - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    spr_gamma_pkg::state_e state_q, state_d;

    logic [NUM_CH*LIN_W-1:0] lin_q, lin_d;
    logic [CODE_W-1:0]       k_q, k_d;
    logic [CODE_W-1:0]       idx_q, idx_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [CH_W-1:0]         ch_q, ch_d;

    logic [LIN_W-1:0]  lobound, upbound;
    logic [LIN_W-1:0]  x_sel, span_w, diff_w, res_w;
    logic [CODE_W-1:0] k_hit;
    logic              commit;

    logic [CODE_W-1:0] code_q [NUM_CH];
    logic [LIN_W-1:0]  res_q  [NUM_CH];
    logic [LIN_W-1:0]  span_q [NUM_CH];

    spr_de_gamma_lut u_lut (
        .idx_i     (idx_q),
        .lobound_o (lobound),
        .upbound_o (upbound)
    );

    always_comb begin
        x_sel  = lin_q[int'(ch_q)*LIN_W +: LIN_W];
        k_hit  = (lobound <= x_sel) ? idx_q : k_q;
        span_w = upbound - lobound;
        // Only meaningful in FETCH, where lobound <= x by construction.
        diff_w = x_sel - lobound;
        res_w  = (diff_w > span_w) ? span_w : diff_w;
    end

    always_comb begin
        state_d = state_q;
        lin_d   = lin_q;
        k_d     = k_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        ch_d    = ch_q;
        commit  = 1'b0;
        unique case (state_q)
            spr_gamma_pkg::IDLE: begin
                if (in_valid) begin
                    lin_d   = in_lin;
                    ch_d    = '0;
                    k_d     = '0;
                    bit_d   = BIT_TOP;
                    idx_d   = IDX_FIRST;
                    state_d = spr_gamma_pkg::SEARCH;
                end
            end
            spr_gamma_pkg::SEARCH: begin
                k_d = k_hit;
                if (bit_q == '0) begin
                    idx_d   = k_hit;
                    state_d = spr_gamma_pkg::FETCH;
                end else begin
                    bit_d = bit_q - BIT_W'(1);
                    idx_d = k_hit | (CODE_W'(1) << (bit_q - BIT_W'(1)));
                end
            end
            spr_gamma_pkg::FETCH: begin
                commit = 1'b1;
                if (ch_q == CH_LAST) begin
                    state_d = spr_gamma_pkg::DONE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    k_d     = '0;
                    bit_d   = BIT_TOP;
                    idx_d   = IDX_FIRST;
                    state_d = spr_gamma_pkg::SEARCH;
                end
            end
            spr_gamma_pkg::DONE: begin
                if (out_ready) begin
                    state_d = spr_gamma_pkg::IDLE;
                end
            end
            default: state_d = spr_gamma_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= spr_gamma_pkg::IDLE;
            lin_q   <= '0;
            k_q     <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            lin_q   <= lin_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            ch_q    <= ch_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                code_q[i] <= '0;
                res_q[i]  <= '0;
                span_q[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_q == CH_W'(i)) begin
                    code_q[i] <= k_q;
                    res_q[i]  <= res_w;
                    span_q[i] <= span_w;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out_code[g*CODE_W +: CODE_W] = code_q[g];
        assign out_res[g*LIN_W +: LIN_W]    = res_q[g];
        assign out_span[g*LIN_W +: LIN_W]   = span_q[g];
    end

    assign in_ready  = (state_q == spr_gamma_pkg::IDLE);
    assign out_valid = (state_q == spr_gamma_pkg::DONE);

endmodule

// File: tb/tb_spr_re_gamma_ctrl.sv
// Scoreboard bench for spr_re_gamma_ctrl against a linear-search breakpoint model.
module tb_spr_re_gamma_ctrl;

    localparam int NCH = 3;
    localparam int LW  = 11;
    localparam int CW  = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NCH*LW-1:0] in_lin = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [NCH*CW-1:0] out_code;
    logic [NCH*LW-1:0] out_res;
    logic [NCH*LW-1:0] out_span;

    spr_re_gamma_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_lin    (in_lin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_res   (out_res),
        .out_span  (out_span)
    );

    always #5 clk = ~clk;

    int b [0:32] = '{0, 32, 64, 96, 128, 160, 192, 224, 256, 288, 320, 352, 384, 424,
                     462, 502, 576, 648, 728, 808, 880, 952, 1084, 1200, 1312, 1424,
                     1536, 1648, 1760, 1856, 1952, 2038, 2040};

    typedef struct {
        logic [NCH*LW-1:0] x;
        logic [NCH*CW-1:0] code;
        logic [NCH*LW-1:0] res;
        logic [NCH*LW-1:0] span;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pushed = 0;
    int   popped = 0;
    int   last_acc = 0;
    bit   rand_rdy = 1'b0;
    bit   rdy_fixed = 1'b0;
    bit   sweep_on = 1'b0;
    int   last_code0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [NCH*LW-1:0] x);
        exp_t e;
        e.x = x;
        for (int c = 0; c < NCH; c++) begin
            int xv, k, sp, r;
            xv = int'(x[c*LW +: LW]);
            k  = 0;
            for (int j = 0; j < 32; j++) if (b[j] <= xv) k = j;
            sp = b[k+1] - b[k];
            r  = xv - b[k];
            if (r > sp) r = sp;
            e.code[c*CW +: CW] = CW'(k);
            e.res[c*LW +: LW]  = LW'(r);
            e.span[c*LW +: LW] = LW'(sp);
        end
        return e;
    endfunction

    function automatic logic [NCH*LW-1:0] pack(input int x0, input int x1, input int x2);
        return {LW'(x2), LW'(x1), LW'(x0)};
    endfunction

    function automatic int rnd_x();
        int k;
        k = int'($urandom_range(0, 32));
        case ($urandom_range(0, 3))
            0:       return b[k];
            1:       return (b[k] > 0) ? b[k] - 1 : 0;
            default: return int'($urandom_range(0, 2047));
        endcase
    endfunction

    // Monitor: sample between edges; a handshake seen here completes on the next rising edge.
    exp_t mon_e;
    bit   prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (acc_q.size() == 0) chk("latency_no_accept", 1, 0);
                else chk("latency", 64'(cyc - acc_q.pop_front()), 18);
            end
            prev_valid = out_valid;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    popped++;
                    for (int c = 0; c < NCH; c++) begin
                        int rv, sv, xv;
                        chk($sformatf("code_ch%0d", c), out_code[c*CW +: CW], mon_e.code[c*CW +: CW]);
                        chk($sformatf("res_ch%0d", c), out_res[c*LW +: LW], mon_e.res[c*LW +: LW]);
                        chk($sformatf("span_ch%0d", c), out_span[c*LW +: LW], mon_e.span[c*LW +: LW]);
                        rv = int'(out_res[c*LW +: LW]);
                        sv = int'(out_span[c*LW +: LW]);
                        xv = int'(mon_e.x[c*LW +: LW]);
                        chk($sformatf("res_span_rule_ch%0d", c),
                            64'((rv < sv) || (rv == sv && xv >= 2040)), 1);
                    end
                    if (sweep_on) begin
                        chk("code_monotonic", 64'(int'(out_code[CW-1:0]) >= last_code0), 1);
                        last_code0 = int'(out_code[CW-1:0]);
                    end
                end
            end
        end
    end

    task automatic send(input logic [NCH*LW-1:0] x);
        int n;
        n = 0;
        in_lin   = x;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(x));
        pushed++;
        @(posedge clk); #1;
        acc_q.push_back(cyc);
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [NCH*LW-1:0] x;
        int n, prev;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_out_res", out_res, 0);
        chk("rst_out_span", out_span, 0);

        rdy_fixed = 1'b1;
        @(posedge clk); #1;
        send(pack(0, 32, 2047));
        drain();
        send(pack(500, 1000, 2039));
        drain();

        // DONE held by backpressure while new input is offered
        rdy_fixed = 1'b0;
        @(posedge clk); #1;
        x = pack(500, 1000, 2039);
        e = model(pack(40, 40, 40));
        e = model(x);
        send(x);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_reach_done", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            in_lin   = pack(7, 7, 7);
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_code", out_code, e.code);
            chk("hold_res", out_res, e.res);
            chk("hold_span", out_span, e.span);
        end
        in_valid  = 1'b0;
        rdy_fixed = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        drain();

        // asynchronous reset during ch1 search
        send(pack(1500, 900, 300));
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_code", out_code, 0);
        chk("abort_res", out_res, 0);
        chk("abort_span", out_span, 0);
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        pushed--;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(pack(100, 1084, 2046));
        drain();

        // back-to-back with consumer always ready
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            send(pack(rnd_x(), rnd_x(), rnd_x()));
            if (i > 0) chk("b2b_spacing", 64'(last_acc - prev), 20);
            prev = last_acc;
        end
        drain();

        // full sweep of each channel
        sweep_on   = 1'b1;
        last_code0 = 0;
        for (int i = 0; i < 2048; i++) begin
            send(pack(i, 2047 - i, int'($urandom_range(0, 2047))));
        end
        drain();
        sweep_on = 1'b0;

        // random traffic with random backpressure and idle gaps
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            send(pack(rnd_x(), rnd_x(), rnd_x()));
        end
        drain();
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk("all_outputs_seen", popped, pushed);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
